video_timing_ctrl: RTL and testbench
====================================

# video_timing_ctrl

- Programmable raster sequencer for the HDMI output path.
- Generates the pixel/line counters and the `hsync`, `vsync` and `de` controls that drive the pattern generator and the three `svo_tmds` encoders.
- Replaces hard-coded counter logic with eight runtime timing fields.
- Timing changes are written to shadow registers and applied atomically at a frame boundary, so the display never sees a torn frame.

## Interface
Parameters:
- `CW`, 12: counter and timing-field width.
- `H_ACTIVE`, 1920; `H_FP`, 88; `H_SYNC`, 44; `H_BP`, 148: horizontal field reset values.
- `V_ACTIVE`, 1080; `V_FP`, 4; `V_SYNC`, 5; `V_BP`, 36: vertical field reset values.
- `SYNC_POL`, 1: 1 = sync active-high, 0 = sync active-low.

Ports:
- `pixclk` in 1: pixel clock; all logic runs on it.
- `reset` in 1: synchronous, active-low reset.
- `en` in 1: 0 freezes counters at 0,0 with outputs idle; 1 runs the raster.
- `cfg_we` in 1: writes `cfg_data` into the shadow field selected by `cfg_sel`.
- `cfg_sel` in 3: field index, 0..7 = H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP.
- `cfg_data` in CW: field value.
- `cfg_commit` in 1: request to apply the shadow set at the next frame wrap.
- `cfg_pending` out 1: a commit is waiting for a frame wrap.
- `cfg_err` out 1: one-cycle pulse when a write is rejected.
- `hsync`, `vsync`, `de` out 1 each: registered raster controls.
- `x`, `y` out CW each: registered counter values.
- `line_start`, `frame_start` out 1 each: one-cycle pulses.

## Operation
- Horizontal region order: active, front porch, sync, back porch.
- `HT` = sum of the four horizontal fields; `VT` = sum of the four vertical fields. Both are computed at apply time.
- `h_cnt` runs 0..HT-1 while `en`=1. At HT-1 it wraps to 0 and `v_cnt` advances, wrapping 0..VT-1.
- `de` = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- `hsync` is asserted (per `SYNC_POL`) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- `vsync` is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). It changes only in cycles where h_cnt = 0.
- `line_start` pulses when h_cnt = 0.
- `frame_start` pulses when h_cnt = 0 and v_cnt = 0.
- `x`/`y` follow h_cnt/v_cnt in every cycle, including blanking.
- Field writes:
  - Update the shadow register only.
  - Writing 0 to ACTIVE or SYNC fields (sel 0, 2, 4, 6) is ignored; `cfg_err` pulses the next cycle.
  - Writing 0 to porch fields is legal.
- Commit:
  - `cfg_commit` sets `cfg_pending`.
  - On the wrap cycle (h_cnt = HT-1, v_cnt = VT-1) with `cfg_pending`=1, the shadow set is copied to the active set, HT/VT are recomputed, and `cfg_pending` clears.
  - A commit arriving in the wrap cycle itself is deferred to the following wrap.
  - Repeat commits while pending are idempotent.
  - Shadow writes while pending are allowed; the values present at the apply cycle win.
- `en` falling:
  - Counters reset to 0 the next cycle.
  - `de`=0; syncs deasserted.
  - `cfg_pending` holds.
  - With `en`=0, a pending commit is applied immediately in the next cycle.
- `reset`=0:
  - Counters 0; shadow and active sets reload the parameter defaults.
  - `cfg_pending`=0.
  - All outputs take reset values, even mid-frame or mid-commit.

## Timing
- Reset values: `de`=0, `hsync`=`vsync`=~SYNC_POL, `x`=`y`=0, `line_start`=`frame_start`=0, `cfg_pending`=0, `cfg_err`=0.
- Latency: outputs are registered one cycle after the counter state they decode. All outputs share the same latency, so `de`, syncs and `x`/`y` stay mutually aligned.
- First cycle after `reset` releases with `en`=1: counters = 0,0. One cycle later `frame_start`=1 and `de`=1.
- The applied config governs from the first cycle of the new frame; the old frame finishes entirely with the old values.
- `cfg_pending` rises the cycle after `cfg_commit` and falls the cycle after the apply.
- Counter width rule: HT and VT must fit in CW bits. Field sums are computed at CW+2 bits. A sum exceeding 2^CW-1 rejects the apply: the active set is kept, `cfg_pending` clears, and `cfg_err` pulses.

## Structure
- Package `video_timing_pkg` holds:
  - field-index localparams `FLD_H_ACTIVE`..`FLD_V_BP`;
  - the 1080p60 default constants;
  - a struct/typedef for one axis (active, fp, sync, bp).
- Sub-module `timing_axis_counter`, instantiated twice (horizontal, vertical):
  - inputs: step enable and the axis fields;
  - outputs: cnt, wrap, in_active, in_sync.
- The top level holds the shadow/active register sets, the commit logic and the output registers.

## Test plan
- Reset defaults, run 2 frames: `frame_start` period = 2200×1125 = 2475000 cycles; `hsync` high 44 cycles starting at `x`=2008; `de` high 1920 cycles per line on lines 0..1079.
- Write H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, V fields 480/10/2/33, then commit mid-frame: current frame keeps 2200×1125; next `frame_start` period = 800×525 = 420000; `cfg_pending` low after the apply.
- Write H_SYNC=0: `cfg_err` pulses one cycle; the shadow value is unchanged; timing is unaffected.
- `cfg_commit` asserted exactly on the wrap cycle: no change at that wrap; applied at the following wrap.
- `en` dropped at `x`=100, `y`=50 for 10 cycles, then raised: `de`=0 and syncs idle during the gap; the raster restarts at 0,0 with `frame_start`.
- `reset`=0 mid-frame with a commit pending: `cfg_pending`=0; the next frame uses the 1080p defaults.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared timing types for the raster sequencer: field indices, 1080p60 defaults, axis field set.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package video_timing_pkg;

    // Storage width of one timing field; the counter width CW must not exceed it.
    localparam int FLD_W = 16;

    // Field index as seen on cfg_sel.
    localparam logic [2:0] FLD_H_ACTIVE = 3'd0;
    localparam logic [2:0] FLD_H_FP     = 3'd1;
    localparam logic [2:0] FLD_H_SYNC   = 3'd2;
    localparam logic [2:0] FLD_H_BP     = 3'd3;
    localparam logic [2:0] FLD_V_ACTIVE = 3'd4;
    localparam logic [2:0] FLD_V_FP     = 3'd5;
    localparam logic [2:0] FLD_V_SYNC   = 3'd6;
    localparam logic [2:0] FLD_V_BP     = 3'd7;

    // 1920x1080 @ 60 Hz (CEA-861 mode 16).
    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_FP     = 88;
    localparam int DEF_H_SYNC   = 44;
    localparam int DEF_H_BP     = 148;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 36;

    // One raster axis, regions in scan order.
    typedef struct packed {
        logic [FLD_W-1:0] active;
        logic [FLD_W-1:0] fp;
        logic [FLD_W-1:0] sync;
        logic [FLD_W-1:0] bp;
    } axis_t;

    // Axis period with two guard bits so an oversize sum is visible rather than wrapped.
    function automatic logic [FLD_W+1:0] axis_total(input axis_t a);
        return (FLD_W+2)'(a.active) + (FLD_W+2)'(a.fp) + (FLD_W+2)'(a.sync) + (FLD_W+2)'(a.bp);
    endfunction

endpackage

// File: rtl/video_timing_ctrl_axis.sv
// One raster axis: position counter plus active/sync region decode.
// Latency: cnt moves on the clock after step; wrap/in_active/in_sync decode the current cnt.
// Backpressure: none; advances whenever step is high, clr forces the count to zero.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int CW = 12
) (
    input  logic          pixclk,
    input  logic          reset,
    input  logic          clr,
    input  logic          step,
    input  axis_t         fld,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          in_active,
    output logic          in_sync
);
    localparam int SW = FLD_W + 2;

    logic [SW-1:0] pos;
    logic [SW-1:0] total;
    logic [SW-1:0] sync_lo;
    logic [SW-1:0] sync_hi;

    // Compare the position against the region boundaries of the applied field set.
    always_comb begin
        pos       = SW'(cnt);
        total     = axis_total(fld);
        sync_lo   = SW'(fld.active) + SW'(fld.fp);
        sync_hi   = sync_lo + SW'(fld.sync);
        wrap      = (pos == total - SW'(1));
        in_active = (pos < SW'(fld.active));
        in_sync   = (pos >= sync_lo) && (pos < sync_hi);
    end

    // Position counter, wrapping at the last position of the axis.
    always_ff @(posedge pixclk) begin
        if (!reset || clr) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// Programmable raster sequencer: shadow/active timing sets, frame-atomic commit, registered sync/de.
// Latency: every output is registered one cycle after the counter state it decodes.
// Backpressure: none; en=0 parks the raster at 0,0 with idle outputs.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int CW       = 12,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic          pixclk,
    input  logic          reset,
    input  logic          en,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_sel,
    input  logic [CW-1:0] cfg_data,
    input  logic          cfg_commit,
    output logic          cfg_pending,
    output logic          cfg_err,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);
    localparam axis_t H_DEF = {FLD_W'(H_ACTIVE), FLD_W'(H_FP), FLD_W'(H_SYNC), FLD_W'(H_BP)};
    localparam axis_t V_DEF = {FLD_W'(V_ACTIVE), FLD_W'(V_FP), FLD_W'(V_SYNC), FLD_W'(V_BP)};

    axis_t            h_shd, v_shd;
    axis_t            h_act, v_act;
    logic             run_q;
    logic             run;
    logic [CW-1:0]    h_cnt, v_cnt;
    logic             h_wrap, v_wrap, h_in_act, v_in_act, h_in_sync, v_in_sync;
    logic             frame_wrap;
    logic             apply;
    logic             wr_bad;
    logic             shd_ovf;
    logic [FLD_W-1:0] wdat;

    // Raster is live once en has been high for a full cycle; this gives the 0,0 hold after (re)start.
    always_ff @(posedge pixclk) begin
        if (!reset) run_q <= 1'b0;
        else        run_q <= en;
    end

    // Commit qualification, write rejection and shadow period overflow.
    always_comb begin
        run        = run_q && en;
        frame_wrap = run && h_wrap && v_wrap;
        apply      = cfg_pending && (frame_wrap || !en);
        wr_bad     = (cfg_data == '0) && !cfg_sel[0];
        shd_ovf    = ((axis_total(h_shd) >> CW) != '0) || ((axis_total(v_shd) >> CW) != '0);
        wdat       = FLD_W'(cfg_data);
    end

    // Shadow field writes; zero ACTIVE/SYNC values are dropped.
    always_ff @(posedge pixclk) begin
        if (!reset) begin
            h_shd <= H_DEF;
            v_shd <= V_DEF;
        end else if (cfg_we && !wr_bad) begin
            case (cfg_sel)
                FLD_H_ACTIVE: h_shd.active <= wdat;
                FLD_H_FP:     h_shd.fp     <= wdat;
                FLD_H_SYNC:   h_shd.sync   <= wdat;
                FLD_H_BP:     h_shd.bp     <= wdat;
                FLD_V_ACTIVE: v_shd.active <= wdat;
                FLD_V_FP:     v_shd.fp     <= wdat;
                FLD_V_SYNC:   v_shd.sync   <= wdat;
                FLD_V_BP:     v_shd.bp     <= wdat;
            endcase
        end
    end

    // Active set swap at the frame wrap; a commit seen in the wrap cycle itself stays pending.
    always_ff @(posedge pixclk) begin
        if (!reset) begin
            h_act       <= H_DEF;
            v_act       <= V_DEF;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            if (apply && !shd_ovf) begin
                h_act <= h_shd;
                v_act <= v_shd;
            end
            cfg_pending <= cfg_commit || (cfg_pending && !apply);
            cfg_err     <= (cfg_we && wr_bad) || (apply && shd_ovf);
        end
    end

    timing_axis_counter #(.CW(CW)) u_h (
        .pixclk    (pixclk),
        .reset     (reset),
        .clr       (!en),
        .step      (run),
        .fld       (h_act),
        .cnt       (h_cnt),
        .wrap      (h_wrap),
        .in_active (h_in_act),
        .in_sync   (h_in_sync)
    );

    timing_axis_counter #(.CW(CW)) u_v (
        .pixclk    (pixclk),
        .reset     (reset),
        .clr       (!en),
        .step      (run && h_wrap),
        .fld       (v_act),
        .cnt       (v_cnt),
        .wrap      (v_wrap),
        .in_active (v_in_act),
        .in_sync   (v_in_sync)
    );

    // Registered raster outputs; idle whenever the raster is not live.
    always_ff @(posedge pixclk) begin
        if (!reset || !run) begin
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            de          <= h_in_act && v_in_act;
            hsync       <= h_in_sync ? SYNC_POL : ~SYNC_POL;
            vsync       <= v_in_sync ? SYNC_POL : ~SYNC_POL;
            x           <= h_cnt;
            y           <= v_cnt;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl on a scaled raster: H 8/2/3/3 (HT=16), V 4/1/2/1 (VT=8).
// Table of per-cycle vectors after reset, then hand-written commit/en/reset/overflow sequences.
module tb_video_timing_ctrl;
    import video_timing_pkg::*;

    localparam int CW  = 12;
    localparam int LIM = 2000;

    logic          pixclk, reset, en, cfg_we, cfg_commit;
    logic [2:0]    cfg_sel;
    logic [CW-1:0] cfg_data;
    logic          cfg_pending, cfg_err, hsync, vsync, de, line_start, frame_start;
    logic [CW-1:0] x, y;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct packed {
        logic        rst, en, we;
        logic [2:0]  sel;
        logic [11:0] dat;
        logic        cm;
        logic [11:0] ex, ey;
        logic        ede, ehs, evs, els, efs, epd, eer;
    } vec_t;

    vec_t tbl [19];

    video_timing_ctrl #(
        .CW(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) dut (
        .pixclk(pixclk), .reset(reset), .en(en),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .cfg_pending(cfg_pending), .cfg_err(cfg_err),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input int r, e, w, s, d, c, ex, ey, d_e, hs, vs, ls, fs, pd, er);
        vec_t v;
        v.rst = 1'(r);  v.en = 1'(e);   v.we = 1'(w);   v.sel = 3'(s);  v.dat = 12'(d);
        v.cm  = 1'(c);  v.ex = 12'(ex); v.ey = 12'(ey); v.ede = 1'(d_e);
        v.ehs = 1'(hs); v.evs = 1'(vs); v.els = 1'(ls); v.efs = 1'(fs);
        v.epd = 1'(pd); v.eer = 1'(er);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic tick();
        @(posedge pixclk);
        #1;
        cyc++;
    endtask

    task automatic write_cfg(input logic [2:0] sel, input int val);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_data = CW'(val);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic write_set(input int ha, hf, hs, hb, va, vf, vs, vb);
        write_cfg(FLD_H_ACTIVE, ha); write_cfg(FLD_H_FP, hf);
        write_cfg(FLD_H_SYNC, hs);   write_cfg(FLD_H_BP, hb);
        write_cfg(FLD_V_ACTIVE, va); write_cfg(FLD_V_FP, vf);
        write_cfg(FLD_V_SYNC, vs);   write_cfg(FLD_V_BP, vb);
    endtask

    task automatic commit_pulse();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        en    = 1'b1;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_fs(input string tag, output int t);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < LIM);
        chk({tag, " frame_start seen"}, int'(frame_start), 1);
        t = cyc;
    endtask

    task automatic wait_xy(input string tag, input int ex, input int ey);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(int'(x) == ex && int'(y) == ey) && n < LIM);
        chk({tag, " position reached"}, int'({x, y}), int'({12'(ex), 12'(ey)}));
    endtask

    // Called on the frame_start sample; walks to the next frame_start and checks one frame.
    task automatic scan_frame(input string tag, input int ht, hs0, hsl, ha, vt, vs0, vsl, va);
        int n = 0, de_n = 0, hs_n = 0, vs_n = 0, hs_x = -1, vs_y = -1, vs_x = -1;
        do begin
            if (de) de_n++;
            if (hsync) begin
                hs_n++;
                if (hs_x < 0) hs_x = int'(x);
            end
            if (vsync) begin
                vs_n++;
                if (vs_y < 0) begin
                    vs_y = int'(y);
                    vs_x = int'(x);
                end
            end
            tick();
            n++;
        end while (!frame_start && n < LIM);
        chk({tag, " frame period"}, n, ht * vt);
        chk({tag, " de cycles"}, de_n, ha * va);
        chk({tag, " hsync cycles"}, hs_n, hsl * vt);
        chk({tag, " hsync start x"}, hs_x, hs0);
        chk({tag, " vsync cycles"}, vs_n, vsl * ht);
        chk({tag, " vsync start y,x"}, vs_y * 4096 + vs_x, vs0 * 4096);
    endtask

    initial begin
        int   t0, t1, bad, n;
        vec_t r;

        reset = 1'b0; en = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0; cfg_commit = 1'b0;

        // rst en we sel dat cm | x y de hs vs ls fs pd er
        tbl[0]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 1, 0, 0);
        tbl[3]  = mk(1, 1, 1, 2, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(1, 1, 1, 7, 0, 0,  2, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1, 0, 0, 0, 1,  3, 0, 1, 0, 0, 0, 0, 1, 0);
        tbl[6]  = mk(1, 1, 0, 0, 0, 0,  4, 0, 1, 0, 0, 0, 0, 1, 0);
        tbl[7]  = mk(1, 1, 0, 0, 0, 0,  5, 0, 1, 0, 0, 0, 0, 1, 0);
        tbl[8]  = mk(1, 1, 0, 0, 0, 0,  6, 0, 1, 0, 0, 0, 0, 1, 0);
        tbl[9]  = mk(1, 1, 0, 0, 0, 0,  7, 0, 1, 0, 0, 0, 0, 1, 0);
        tbl[10] = mk(1, 1, 0, 0, 0, 0,  8, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[11] = mk(1, 1, 0, 0, 0, 0,  9, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[12] = mk(1, 1, 0, 0, 0, 0, 10, 0, 0, 1, 0, 0, 0, 1, 0);
        tbl[13] = mk(1, 1, 0, 0, 0, 0, 11, 0, 0, 1, 0, 0, 0, 1, 0);
        tbl[14] = mk(1, 1, 0, 0, 0, 0, 12, 0, 0, 1, 0, 0, 0, 1, 0);
        tbl[15] = mk(1, 1, 0, 0, 0, 0, 13, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[16] = mk(1, 1, 0, 0, 0, 0, 14, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[17] = mk(1, 1, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[18] = mk(1, 1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 1, 0, 1, 0);

        for (int i = 0; i < 19; i++) begin
            r          = tbl[i];
            reset      = r.rst;
            en         = r.en;
            cfg_we     = r.we;
            cfg_sel    = r.sel;
            cfg_data   = r.dat;
            cfg_commit = r.cm;
            tick();
            chk($sformatf("vec%0d {x,y,de,hs,vs,ls,fs,pend,err}", i),
                int'({x, y, de, hsync, vsync, line_start, frame_start, cfg_pending, cfg_err}),
                int'({r.ex, r.ey, r.ede, r.ehs, r.evs, r.els, r.efs, r.epd, r.eer}));
        end
        cfg_we = 1'b0;
        cfg_commit = 1'b0;

        // Defaults over two frames.
        do_reset();
        wait_fs("A", t0);
        scan_frame("A1", 16, 10, 3, 8, 8, 5, 2, 4);
        scan_frame("A2", 16, 10, 3, 8, 8, 5, 2, 4);

        // Mid-frame commit: old frame completes, new timing from the next frame.
        do_reset();
        wait_fs("B0", t0);
        repeat (3) tick();
        write_set(6, 1, 2, 1, 3, 0, 2, 1);
        commit_pulse();
        chk("B pending set", int'(cfg_pending), 1);
        wait_fs("B1", t1);
        chk("B old frame period", t1 - t0, 128);
        chk("B pending cleared", int'(cfg_pending), 0);
        scan_frame("B new", 10, 7, 2, 6, 6, 3, 2, 3);

        // Zero H_SYNC write is rejected and leaves the shadow intact.
        write_cfg(FLD_H_SYNC, 0);
        chk("C err pulse", int'(cfg_err), 1);
        tick();
        chk("C err one cycle", int'(cfg_err), 0);
        commit_pulse();
        wait_fs("C", t0);
        scan_frame("C shadow kept", 10, 7, 2, 6, 6, 3, 2, 3);

        // Commit exactly in the wrap cycle is deferred one frame.
        write_set(4, 1, 1, 2, 2, 1, 1, 1);
        wait_xy("D", 8, 5);
        commit_pulse();
        wait_fs("D0", t0);
        chk("D deferred pending", int'(cfg_pending), 1);
        scan_frame("D old", 10, 7, 2, 6, 6, 3, 2, 3);
        chk("D applied", int'(cfg_pending), 0);
        scan_frame("D new", 8, 5, 1, 4, 5, 3, 1, 2);

        // en gap mid-frame, with a commit applied while idle.
        wait_xy("E", 5, 2);
        en  = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                cfg_we   = 1'b1;
                cfg_sel  = FLD_H_ACTIVE;
                cfg_data = CW'(5);
            end
            if (i == 1) cfg_commit = 1'b1;
            tick();
            cfg_we     = 1'b0;
            cfg_commit = 1'b0;
            if (de || hsync || vsync || line_start || frame_start || x != '0 || y != '0) bad++;
            if (i == 1) chk("E pending set while idle", int'(cfg_pending), 1);
            if (i == 2) chk("E applied while idle", int'(cfg_pending), 0);
        end
        chk("E idle output cycles", bad, 0);
        en = 1'b1;
        tick();
        chk("E restart hold {fs,de,x}", int'({frame_start, de, x}), 0);
        tick();
        chk("E restart {fs,de}", int'({frame_start, de}), 3);
        chk("E restart {x,y}", int'({x, y}), 0);
        scan_frame("E new", 9, 6, 1, 5, 5, 3, 1, 2);

        // Reset mid-frame with a commit pending.
        repeat (7) tick();
        write_cfg(FLD_H_ACTIVE, 3);
        commit_pulse();
        chk("F pending before reset", int'(cfg_pending), 1);
        reset = 1'b0;
        tick();
        chk("F reset outputs", int'({cfg_pending, cfg_err, de, hsync, vsync, line_start, frame_start, x, y}), 0);
        tick();
        reset = 1'b1;
        wait_fs("F", t0);
        scan_frame("F defaults", 16, 10, 3, 8, 8, 5, 2, 4);

        // Oversize horizontal period: apply rejected, active set kept.
        write_cfg(FLD_H_ACTIVE, 4000);
        write_cfg(FLD_H_BP, 200);
        commit_pulse();
        n = 0;
        while (cfg_pending && n < LIM) begin
            tick();
            n++;
        end
        chk("G pending cleared", int'(cfg_pending), 0);
        chk("G err on reject", int'(cfg_err), 1);
        tick();
        chk("G err one cycle", int'(cfg_err), 0);
        wait_fs("G", t0);
        scan_frame("G kept", 16, 10, 3, 8, 8, 5, 2, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
